regfile_wb: RTL and testbench
=============================

# regfile_wb

Writeback stage and integer register file for the RISC-V core. Consumes the execute-stage result bus (`rd`, `rd_res`, `rf_wr_en`), commits results into a 32 x 32-bit register file, and serves the decode stage's operand reads with same-cycle write bypass. Tracks in-flight destination registers with a scoreboard and raises a hazard stall to decode.

## Interface
- `XLEN`, 32: register and data width.
- `NREGS`, 32: architectural registers. x0 is hardwired to zero.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_bus_i`  in  `core::pipeline_bus_t`  execute-stage result bus. Fields used: `rd`[4:0], `rd_res`[31:0], `rf_wr_en`, `pipeline_stall`.
- `rs1_addr_i`  in  5  decode operand 1 index.
- `rs2_addr_i`  in  5  decode operand 2 index.
- `issue_valid_i`  in  1  decode presents an instruction for issue this cycle.
- `issue_wr_i`  in  1  the issuing instruction writes `issue_rd_i`.
- `issue_rd_i`  in  5  destination of the issuing instruction.
- `flush_i`  in  1  pipeline flush; clears the scoreboard.
- `rs1_data_o`  out  32  operand 1 data (combinational).
- `rs2_data_o`  out  32  operand 2 data (combinational).
- `hazard_stall_o`  out  1  issue blocked this cycle (combinational).
- `retire_cnt_o`  out  32  count of committed register writes.

## Operation
- **Commit condition:** `wb_we = rf_wr_en & ~pipeline_stall & (rd != 0)`.
  - On a rising edge with `wb_we`, write `regs[rd] <= rd_res`.
  - `retire_cnt_o` increments by 1 and wraps modulo 2^32.
  - A write with `rd = 0` is dropped. It is not counted and the scoreboard is not touched.
- **Read ports:** for each port, in priority order:
  - address 0: return 0.
  - `wb_we` and address == `wb_bus_i.rd`: return `wb_bus_i.rd_res` (write-through bypass).
  - otherwise: return `regs[addr]`.
- **Scoreboard:** `busy[31:1]` holds one bit per register; `busy[0]` is constant 0.
  - Effective busy: `eff_busy[r] = busy[r] & ~(wb_we & wb_bus_i.rd == r)`. A register being committed this cycle is treated as available.
- **Hazard:** `hazard_stall_o = issue_valid_i & ~flush_i & (eff_busy[rs1] | eff_busy[rs2] | (issue_wr_i & eff_busy[issue_rd_i]))`.
  - This covers RAW on both sources and WAW on the destination.
- **Issue accept:** `accept = issue_valid_i & ~hazard_stall_o & ~flush_i`.
  - On the edge with `accept & issue_wr_i & issue_rd_i != 0`: set `busy[issue_rd_i]`.
- **Clear:** on the edge with `wb_we`: clear `busy[wb_bus_i.rd]`.
- **Simultaneous set and clear of the same register:** set wins. The register is busy for the new producer.
- **Flush:**
  - `flush_i` clears all busy bits on the edge and blocks issue-side set.
  - A commit arriving in the same cycle as flush is still written to `regs` and counted.
- **Reset (asynchronous, takes effect mid-cycle):**
  - `regs` all 0.
  - `busy` all 0.
  - `retire_cnt_o` = 0.
  - Combinational outputs then follow the reset state: `rs*_data_o` = 0 unless bypassed, `hazard_stall_o` = 0.

## Timing
- Commit latency: 1 edge. A register read in the cycle after the commit edge returns the new value from the array.
- Bypass makes the value visible in the commit cycle itself, so producer-to-consumer latency is 0 extra cycles.
- `hazard_stall_o`, `rs1_data_o` and `rs2_data_o` are purely combinational from the inputs and state. Decode holds its inputs while the stall is high.
- Scoreboard updates occur only on rising edges. The hazard decision in cycle N uses `busy` as of the end of cycle N-1, plus same-cycle commit forwarding.
- No multi-cycle state beyond the scoreboard. `retire_cnt_o` updates one edge after the commit cycle.

## Test plan
- **Reset and x0:**
  - Assert `rst` mid-cycle after writes: all reads return 0, `retire_cnt_o` = 0, stall = 0.
  - Commit `rd=0`, `rd_res=0xDEADBEEF`: x0 still reads 0 and the count is unchanged.
- **Commit and bypass:**
  - In the commit cycle for `rd=5`, `rd_res=0x12345678`, read rs1=5: returns `0x12345678`.
  - Next cycle, with no bypass: still `0x12345678`. `retire_cnt_o` = 1.
- **RAW stall:**
  - Issue `wr rd=7` (accepted).
  - Next cycle, issue `rs2=7`: stall = 1, held for 3 cycles.
  - In the cycle x7 commits `0xA5`: stall = 0 and `rs2_data_o` = `0xA5`.
- **WAW and set-wins:**
  - With x3 busy, issue `wr rd=3`: stalls.
  - With x3 committing in the same cycle as a new issue `wr rd=3`: accepted and x3 remains busy afterwards.
- **Flush:** make x4, x9 and x20 busy, then assert `flush_i` with a concurrent commit of x9=`0x55`.
  - Next cycle: all busy bits are clear, x9 reads `0x55`, and issue of `rs1=20` is accepted.
- **Stalled bus and counter wrap:**
  - Commit with `pipeline_stall=1`: the register file and count are unchanged.
  - Force `retire_cnt_o` to `0xFFFFFFFF` via 2^32-1 commits (or a backdoor), then one more commit: it reads 0.

Source files
------------

// File: rtl/regfile_wb_if.sv
// ---------------------------------------------------------------------------
// core package + regfile_wb_if
//
// Purpose:
//   core::pipeline_bus_t is the execute-stage result bus that feeds the
//   writeback stage. regfile_wb_if bundles the writeback bus, the decode
//   operand/issue signals and the register file's responses into one
//   interface.
//
// Modports:
//   master : the pipeline side. It drives the wb bus, the operand addresses,
//            the issue request and flush. It observes the read data, the
//            hazard stall and the retire count.
//   slave  : the regfile_wb side, with the opposite directions.
//
// Signals:
//   wb_bus_i        execute-stage result bus (rd, rd_res, rf_wr_en,
//                   pipeline_stall)
//   rs1_addr_i      decode operand 1 index
//   rs2_addr_i      decode operand 2 index
//   issue_valid_i   decode presents an instruction for issue this cycle
//   issue_wr_i      the issuing instruction writes issue_rd_i
//   issue_rd_i      destination register of the issuing instruction
//   flush_i         pipeline flush; clears the scoreboard
//   rs1_data_o      operand 1 data (combinational)
//   rs2_data_o      operand 2 data (combinational)
//   hazard_stall_o  issue blocked this cycle (combinational)
//   retire_cnt_o    count of committed register writes
// ---------------------------------------------------------------------------
package core;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_res;
        logic        rf_wr_en;
        logic        pipeline_stall;
    } pipeline_bus_t;
endpackage

interface regfile_wb_if;
    core::pipeline_bus_t wb_bus_i;
    logic [4:0]          rs1_addr_i;
    logic [4:0]          rs2_addr_i;
    logic                issue_valid_i;
    logic                issue_wr_i;
    logic [4:0]          issue_rd_i;
    logic                flush_i;
    logic [31:0]         rs1_data_o;
    logic [31:0]         rs2_data_o;
    logic                hazard_stall_o;
    logic [31:0]         retire_cnt_o;

    modport master (
        output wb_bus_i, rs1_addr_i, rs2_addr_i,
        output issue_valid_i, issue_wr_i, issue_rd_i, flush_i,
        input  rs1_data_o, rs2_data_o, hazard_stall_o, retire_cnt_o
    );

    modport slave (
        input  wb_bus_i, rs1_addr_i, rs2_addr_i,
        input  issue_valid_i, issue_wr_i, issue_rd_i, flush_i,
        output rs1_data_o, rs2_data_o, hazard_stall_o, retire_cnt_o
    );
endinterface

// File: rtl/regfile_wb.sv
// ---------------------------------------------------------------------------
// regfile_wb
//
// Purpose:
//   Writeback stage and integer register file. It commits execute-stage
//   results into a NREGS x XLEN register file and serves two combinational
//   operand reads. A read bypasses the value being written in the same
//   cycle. A busy scoreboard tracks destinations that are still in flight
//   and blocks issue on RAW and WAW hazards.
//
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  regfile_wb_if.slave. It carries the wb bus and the decode
//        operand/issue inputs in, and the operand data, hazard stall and
//        retire count out.
// ---------------------------------------------------------------------------
module regfile_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // ---------------------------------------------------------------------
    // Writeback decode
    // ---------------------------------------------------------------------
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_res;
    logic            wb_we;

    assign wb_rd  = AW'(bus.wb_bus_i.rd);
    assign wb_res = XLEN'(bus.wb_bus_i.rd_res);
    // Writes to x0 are dropped entirely. They are not counted and they do
    // not touch the scoreboard.
    assign wb_we  = bus.wb_bus_i.rf_wr_en & ~bus.wb_bus_i.pipeline_stall
                    & (wb_rd != '0);

    // ---------------------------------------------------------------------
    // Register array
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (gi == 0) begin
                    // x0 stays at zero, so this flop is constant.
                    regs_d[gi] = '0;
                end else if (wb_we && (wb_rd == AW'(gi))) begin
                    regs_d[gi] = wb_res;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Read ports with write-through bypass
    // ---------------------------------------------------------------------
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];

    assign rd_addr[0] = AW'(bus.rs1_addr_i);
    assign rd_addr[1] = AW'(bus.rs2_addr_i);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                rd_data[gi] = '0;
                if (rd_addr[gi] == '0) begin
                    rd_data[gi] = '0;
                end else if (wb_we && (rd_addr[gi] == wb_rd)) begin
                    // The consumer sees the producer's result in the commit
                    // cycle itself.
                    rd_data[gi] = wb_res;
                end else begin
                    rd_data[gi] = regs_q[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign bus.rs1_data_o = 32'(rd_data[0]);
    assign bus.rs2_data_o = 32'(rd_data[1]);

    // ---------------------------------------------------------------------
    // Scoreboard and hazard detection
    // ---------------------------------------------------------------------
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] commit_hot;
    logic [NREGS-1:0] eff_busy;
    logic [AW-1:0]    iss_rd;
    logic             raw_hit;
    logic             waw_hit;
    logic             hazard;
    logic             accept;

    assign iss_rd = AW'(bus.issue_rd_i);

    always_comb begin
        commit_hot = '0;
        if (wb_we) begin
            commit_hot[wb_rd] = 1'b1;
        end
    end

    // A register that commits this cycle is already available. This
    // combines with the read bypass to give zero-bubble forwarding.
    assign eff_busy = busy_q & ~commit_hot;

    assign raw_hit = eff_busy[rd_addr[0]] | eff_busy[rd_addr[1]];
    assign waw_hit = bus.issue_wr_i & eff_busy[iss_rd];
    assign hazard  = bus.issue_valid_i & ~bus.flush_i & (raw_hit | waw_hit);
    assign accept  = bus.issue_valid_i & ~hazard & ~bus.flush_i;

    assign bus.hazard_stall_o = hazard;

    always_comb begin
        busy_d = busy_q;
        if (bus.flush_i) begin
            // A flush discards every in-flight producer. The concurrent
            // commit is still written through the register path above.
            busy_d = '0;
        end else begin
            busy_d = busy_d & ~commit_hot;
            // The set is applied after the clear. When one register
            // commits and is re-issued in the same cycle, it stays busy
            // for the new producer.
            if (accept && bus.issue_wr_i && (iss_rd != '0)) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ---------------------------------------------------------------------
    // Retire counter (wraps modulo 2^XLEN)
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] retire_cnt_q;
    logic [XLEN-1:0] retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_we) begin
            retire_cnt_d = retire_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.retire_cnt_o = 32'(retire_cnt_q);

endmodule

// File: tb/tb_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb
//
// Purpose:
//   Scoreboard bench for regfile_wb. The driver applies one cycle of inputs
//   just after the rising edge. It asks a behavioural model for the expected
//   combinational outputs of that cycle and queues them. A monitor pops the
//   queue on every falling edge and compares. The model is kept as plain
//   arrays and is advanced at the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_if ifc ();

    regfile_wb #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] m_cnt;

    typedef struct {
        string       tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = '0;
    endfunction

    function automatic logic [31:0] m_read(input logic we, input logic [4:0] rd,
                                           input logic [31:0] res, input logic [4:0] a);
        if (a == 0)              return 32'd0;
        if (we && a == rd)       return res;
        return m_regs[a];
    endfunction

    function automatic bit m_eff(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return m_busy[r] && !(we && r == rd);
    endfunction

    // One full cycle. It is entered just after a rising edge and returns
    // just after the next one.
    task automatic drive(input logic en, input logic stl, input logic [4:0] rd,
                         input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic iw, input logic [4:0] ird,
                         input logic fl, input string tag);
        logic we;
        logic st;
        exp_t e;
        ifc.wb_bus_i      = '{rd: rd, rd_res: res, rf_wr_en: en, pipeline_stall: stl};
        ifc.rs1_addr_i    = a1;
        ifc.rs2_addr_i    = a2;
        ifc.issue_valid_i = iv;
        ifc.issue_wr_i    = iw;
        ifc.issue_rd_i    = ird;
        ifc.flush_i       = fl;

        we = en && !stl && (rd != 0);
        st = iv && !fl && (m_eff(we, rd, a1) || m_eff(we, rd, a2) || (iw && m_eff(we, rd, ird)));
        e.tag = tag;
        e.r1  = m_read(we, rd, res, a1);
        e.r2  = m_read(we, rd, res, a2);
        e.st  = st;
        e.cnt = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        if (we) begin
            m_regs[rd] = res;
            m_cnt      = m_cnt + 32'd1;
        end
        if (fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (we) m_busy[rd] = 1'b0;
            if (iv && !st && iw && ird != 0) m_busy[ird] = 1'b1;
        end
        #1;
    endtask

    // Reset is raised mid-cycle, with reads of live registers and an issue
    // request that would otherwise hit busy registers.
    task automatic reset_cycle(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        exp_t e;
        ifc.wb_bus_i      = '{rd: 5'd0, rd_res: 32'd0, rf_wr_en: 1'b0, pipeline_stall: 1'b0};
        ifc.rs1_addr_i    = a1;
        ifc.rs2_addr_i    = a2;
        ifc.issue_valid_i = 1'b1;
        ifc.issue_wr_i    = 1'b1;
        ifc.issue_rd_i    = a1;
        ifc.flush_i       = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        e.tag = tag;
        e.r1  = 32'd0;
        e.r2  = 32'd0;
        e.st  = 1'b0;
        e.cnt = 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        drive(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 1'b0, 5'd0, 1'b0, tag);
    endtask

    task automatic check(input string name, input string tag,
                         input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s [%s]: got %08h, required %08h", name, tag, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_data", e.tag, ifc.rs1_data_o, e.r1);
            check("rs2_data", e.tag, ifc.rs2_data_o, e.r2);
            check("hazard_stall", e.tag, {31'd0, ifc.hazard_stall_o}, {31'd0, e.st});
            check("retire_cnt", e.tag, ifc.retire_cnt_o, e.cnt);
            $display("txn %-14s rs1=%08h rs2=%08h stall=%0d cnt=%08h",
                     e.tag, ifc.rs1_data_o, ifc.rs2_data_o, ifc.hazard_stall_o, ifc.retire_cnt_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        ifc.wb_bus_i      = '0;
        ifc.rs1_addr_i    = '0;
        ifc.rs2_addr_i    = '0;
        ifc.issue_valid_i = 1'b0;
        ifc.issue_wr_i    = 1'b0;
        ifc.issue_rd_i    = '0;
        ifc.flush_i       = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        reset_cycle(5'd1, 5'd2, "reset0");

        // commit + bypass, then array read
        drive(1, 0, 5'd5, 32'h12345678, 5'd5, 5'd0, 0, 0, 5'd0, 0, "bypass_x5");
        idle(5'd5, 5'd0, "array_x5");
        // x0 write dropped
        drive(1, 0, 5'd0, 32'hDEADBEEF, 5'd0, 5'd5, 0, 0, 5'd0, 0, "x0_write");
        idle(5'd0, 5'd5, "x0_after");

        // RAW stall on rs2
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd7, 0, "issue_wr7");
        for (int i = 0; i < 3; i++)
            drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd7, 1, 0, 5'd0, 0, "raw_stall7");
        drive(1, 0, 5'd7, 32'h000000A5, 5'd0, 5'd7, 1, 0, 5'd0, 0, "raw_release7");

        // WAW and set-wins
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd3, 0, "issue_wr3");
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd3, 0, "waw_stall3");
        drive(1, 0, 5'd3, 32'h33, 5'd0, 5'd0, 1, 1, 5'd3, 0, "setwins3");
        drive(0, 0, 5'd0, 32'd0, 5'd3, 5'd0, 1, 0, 5'd0, 0, "still_busy3");
        drive(1, 0, 5'd3, 32'h34, 5'd0, 5'd0, 0, 0, 5'd0, 0, "retire3");

        // flush with concurrent commit
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd4, 0, "issue_wr4");
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd9, 0, "issue_wr9");
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd20, 0, "issue_wr20");
        drive(1, 0, 5'd9, 32'h55, 5'd20, 5'd4, 1, 1, 5'd4, 1, "flush");
        drive(0, 0, 5'd0, 32'd0, 5'd20, 5'd9, 1, 0, 5'd0, 0, "post_flush");
        drive(0, 0, 5'd0, 32'd0, 5'd9, 5'd4, 1, 1, 5'd4, 0, "post_flush2");

        // stalled bus
        drive(1, 1, 5'd6, 32'hCAFEF00D, 5'd6, 5'd0, 0, 0, 5'd0, 0, "bus_stalled");
        idle(5'd6, 5'd5, "after_stall");

        // counter wrap through a backdoor load of the next-count value
        force dut.retire_cnt_d = 32'hFFFF_FFFF;
        idle(5'd0, 5'd0, "preload_cnt");
        release dut.retire_cnt_d;
        m_cnt = 32'hFFFF_FFFF;
        drive(1, 0, 5'd8, 32'h88, 5'd8, 5'd0, 0, 0, 5'd0, 0, "wrap_commit");
        idle(5'd8, 5'd0, "wrapped");

        // reset mid-cycle after writes and busy state
        drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 1, 5'd5, 0, "issue_wr5");
        reset_cycle(5'd5, 5'd9, "reset_mid");
        idle(5'd5, 5'd9, "after_reset");

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic        en, stl, iv, iw, fl;
            logic [4:0]  rd, a1, a2, ird;
            logic [31:0] res;
            en  = ($urandom_range(0, 99) < 45);
            stl = ($urandom_range(0, 99) < 15);
            rd  = 5'($urandom_range(0, 7));
            res = $urandom;
            a1  = 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            iv  = ($urandom_range(0, 99) < 60);
            iw  = ($urandom_range(0, 99) < 60);
            ird = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 99) < 4);
            drive(en, stl, rd, res, a1, a2, iv, iw, ird, fl, "random");
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
